// File: rtl/lsu_byte_master_pkg.sv
// ============================================================================
// Module      : lsu_byte_master_pkg
// Description : Shared load/store definitions: DM_* MemOp encodings, access
//               width constants, LSU state encoding and request helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_byte_master_pkg;

  // MemOp encodings shared with the CPU memory stage
  localparam logic [2:0] DM_NOP           = 3'd0;
  localparam logic [2:0] DM_BYTE          = 3'd1;
  localparam logic [2:0] DM_HALF          = 3'd2;
  localparam logic [2:0] DM_WORD          = 3'd3;
  localparam logic [2:0] DM_BYTE_UNSIGNED = 3'd4;
  localparam logic [2:0] DM_HALF_UNSIGNED = 3'd5;

  // Access widths in bytes
  localparam int BYTE = 1;
  localparam int HALF = 2;
  localparam int WORD = 4;

  // LSU sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Index of the final byte of an access (n-1); only meaningful for legal ops
  function automatic logic [1:0] last_idx(input logic [2:0] op);
    case (op)
      DM_HALF, DM_HALF_UNSIGNED: last_idx = 2'(HALF - 1);
      DM_WORD:                   last_idx = 2'(WORD - 1);
      default:                   last_idx = 2'(BYTE - 1);
    endcase
  endfunction

  // A MemOp is legal if it names a width, and unsigned variants are load-only
  function automatic logic op_is_legal(input logic [2:0] op, input logic write);
    case (op)
      DM_BYTE, DM_HALF, DM_WORD:          op_is_legal = 1'b1;
      DM_BYTE_UNSIGNED, DM_HALF_UNSIGNED: op_is_legal = !write;
      default:                            op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_byte_master_extend.sv
// ============================================================================
// Module      : lsu_extend
// Description : Sign/zero extension of the assembled load bytes by MemOp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_extend
  import lsu_byte_master_pkg::*;
(
  input  logic [31:0] i_asm,
  input  logic [2:0]  i_mem_op,
  output logic [31:0] o_data
);

  // Select extension from the access width and signedness
  always_comb begin
    o_data = i_asm;
    case (i_mem_op)
      DM_BYTE:          o_data = {{24{i_asm[7]}}, i_asm[7:0]};
      DM_BYTE_UNSIGNED: o_data = {24'h000000, i_asm[7:0]};
      DM_HALF:          o_data = {{16{i_asm[15]}}, i_asm[15:0]};
      DM_HALF_UNSIGNED: o_data = {16'h0000, i_asm[15:0]};
      default:          o_data = i_asm;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_byte_master.sv
// ============================================================================
// Module      : lsu_byte_master
// Description : Serialises one CPU load/store into 1/2/4 little-endian byte
//               accesses, assembles and extends load data, and returns a
//               one-cycle response pulse.
//               Optional macro LSU_ALIGN_CHECK_EN rejects misaligned
//               half/word requests with respErr instead of running them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_byte_master
  import lsu_byte_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [2:0]            MemOp,
  output logic                  respValid,
  output logic                  respErr,
  output logic [DATA_WIDTH-1:0] readData,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memWData,
  input  logic [7:0]            memRData,
  output logic                  memRead,
  output logic                  memWrite,
  input  logic                  memReady
);

  lsu_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_op;
  logic                  r_write;
  logic [1:0]            r_idx;
  logic [1:0]            r_last;
  logic [31:0]           r_asm;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_mem_read;
  logic                  r_mem_write;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_req_ok;
  logic [1:0]            w_idx_next;
  logic [31:0]           w_asm_next;
  logic [31:0]           w_ext;

  assign w_accept   = reqValid && r_req_ready;
  assign w_idx_next = r_idx + 2'd1;

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misaligned = (((MemOp == DM_HALF) || (MemOp == DM_HALF_UNSIGNED)) && address[0])
                     || ((MemOp == DM_WORD) && (address[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_req_ok = op_is_legal(MemOp, reqWrite) && !w_misaligned;

  // Assembly register with the byte currently returned by memory merged in
  always_comb begin
    w_asm_next                 = r_asm;
    w_asm_next[8*r_idx +: 8]   = memRData;
  end

  lsu_extend u_extend (
    .i_asm    (w_asm_next),
    .i_mem_op (r_op),
    .o_data   (w_ext)
  );

  // Request sequencer with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_wdata      <= '0;
      r_op         <= DM_NOP;
      r_write      <= 1'b0;
      r_idx        <= 2'd0;
      r_last       <= 2'd0;
      r_asm        <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_read_data  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_base      <= address;
            r_wdata     <= writeData;
            r_op        <= MemOp;
            r_write     <= reqWrite;
            r_idx       <= 2'd0;
            r_last      <= last_idx(MemOp);
            r_asm       <= 32'h0;
            r_req_ready <= 1'b0;
            r_read_data <= '0;
            if (w_req_ok) begin
              // Present byte 0 in the cycle right after the accept
              r_state     <= ST_ACCESS;
              r_mem_addr  <= address;
              r_mem_wdata <= writeData[7:0];
              r_mem_read  <= !reqWrite;
              r_mem_write <= reqWrite;
            end else begin
              // Rejected requests skip memory entirely
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (memReady) begin
            if (!r_write) begin
              r_asm <= w_asm_next;
            end
            if (r_idx == r_last) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_read_data  <= r_write ? '0 : w_ext;
              r_mem_addr   <= '0;
              r_mem_wdata  <= 8'h00;
              r_mem_read   <= 1'b0;
              r_mem_write  <= 1'b0;
            end else begin
              r_idx       <= w_idx_next;
              r_mem_addr  <= r_base + ADDR_WIDTH'(w_idx_next);
              r_mem_wdata <= r_wdata[8*w_idx_next +: 8];
            end
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign reqReady  = r_req_ready;
  assign respValid = r_resp_valid;
  assign respErr   = r_resp_err;
  assign readData  = r_read_data;
  assign memAddr   = r_mem_addr;
  assign memWData  = r_mem_wdata;
  assign memRead   = r_mem_read;
  assign memWrite  = r_mem_write;

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_master.sv
// ============================================================================
// Module      : tb_lsu_byte_master
// Description : Self-checking bench for lsu_byte_master against a byte-array
//               memory reference model; honours LSU_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_byte_master;
  import lsu_byte_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, reqWrite;
  logic [31:0] address, writeData;
  logic [2:0]  MemOp;
  logic        respValid, respErr;
  logic [31:0] readData, memAddr;
  logic [7:0]  memWData, memRData;
  logic        memRead, memWrite, memReady;

  logic [7:0]  dut_mem [256];
  logic [7:0]  ref_mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign memRData = dut_mem[memAddr[7:0]];

  lsu_byte_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqWrite  (reqWrite),
    .address   (address),
    .writeData (writeData),
    .MemOp     (MemOp),
    .respValid (respValid),
    .respErr   (respErr),
    .readData  (readData),
    .memAddr   (memAddr),
    .memWData  (memWData),
    .memRData  (memRData),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .memReady  (memReady)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Bytes moved by a MemOp, 0 when the encoding names no width
  function automatic int op_bytes(input logic [2:0] op);
    case (op)
      DM_BYTE, DM_BYTE_UNSIGNED: return 1;
      DM_HALF, DM_HALF_UNSIGNED: return 2;
      DM_WORD:                   return 4;
      default:                   return 0;
    endcase
  endfunction

  function automatic bit model_err(input bit w, input logic [31:0] a, input logic [2:0] op);
    bit e;
    e = (op_bytes(op) == 0) || (w && (op == DM_BYTE_UNSIGNED || op == DM_HALF_UNSIGNED));
`ifdef LSU_ALIGN_CHECK_EN
    if (op_bytes(op) == 2 && (a % 2) != 0) e = 1;
    if (op_bytes(op) == 4 && (a % 4) != 0) e = 1;
`endif
    return e;
  endfunction

  // Little-endian value from the reference memory, then extended
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v;
    logic [31:0] ai;
    v = 0;
    for (int i = 0; i < op_bytes(op); i++) begin
      ai = a + i;
      v = v + (32'(ref_mem[ai[7:0]]) << (8 * i));
    end
    case (op)
      DM_BYTE: return (v >= 32'h80)   ? v + 32'hFFFFFF00 : v;
      DM_HALF: return (v >= 32'h8000) ? v + 32'hFFFF0000 : v;
      default: return v;
    endcase
  endfunction

  // One request; abort_at >= 0 pulls reset when that byte is presented
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] op, input int stall_at, input int stall_len,
                        input int abort_at);
    bit          err;
    int          n, i, stalls, iters, exp_stalls;
    logic [31:0] exp_rd, s_addr, ea;
    logic [7:0]  s_wd, eb;
    bit          rdy;
    err    = model_err(w, a, op);
    n      = op_bytes(op);
    exp_rd = (!w && !err) ? model_load(a, op) : 32'h0;
    @(negedge clk);
    check_value("req_ready_idle", {31'h0, reqReady}, 32'h1);
    reqValid = 1; reqWrite = w; address = a; writeData = d; MemOp = op; memReady = 1;
    @(posedge clk);
    #1;
    reqValid = 0; reqWrite = 1'($urandom); address = $urandom; writeData = $urandom;
    MemOp = 3'($urandom);
    if (err) begin
      @(negedge clk);
      check_value("err_resp_valid", {31'h0, respValid}, 32'h1);
      check_value("err_resp_err", {31'h0, respErr}, 32'h1);
      check_value("err_strobes", {30'h0, memRead, memWrite}, 32'h0);
      check_value("err_read_data", readData, 32'h0);
      @(negedge clk);
      check_value("err_resp_drop", {31'h0, respValid}, 32'h0);
      check_value("err_ready_back", {31'h0, reqReady}, 32'h1);
      return;
    end
    i = 0; stalls = stall_len; iters = 0;
    exp_stalls = (stall_at >= 0 && stall_at < n) ? stall_len : 0;
    while (i < n) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n = 0;
        #1;
        check_value("rst_ready", {31'h0, reqReady}, 32'h1);
        check_value("rst_resp", {30'h0, respValid, respErr}, 32'h0);
        check_value("rst_strobes", {30'h0, memRead, memWrite}, 32'h0);
        check_value("rst_mem_addr", memAddr, 32'h0);
        check_value("rst_wdata", {24'h0, memWData}, 32'h0);
        check_value("rst_read_data", readData, 32'h0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
          @(negedge clk);
          check_value("post_rst_no_resp", {31'h0, respValid}, 32'h0);
        end
        return;
      end
      ea = a + i;
      check_value("acc_resp_low", {31'h0, respValid}, 32'h0);
      check_value("acc_ready_low", {31'h0, reqReady}, 32'h0);
      check_value("acc_mem_addr", memAddr, ea);
      check_value("acc_strobes", {30'h0, memRead, memWrite}, {30'h0, !w, w});
      eb = d[8*i +: 8];
      if (w) check_value("acc_wdata", {24'h0, memWData}, {24'h0, eb});
      if (i == stall_at && stalls > 0) begin
        memReady = 0;
        stalls--;
      end else begin
        memReady = 1;
      end
      rdy = memReady; s_addr = memAddr; s_wd = memWData;
      @(posedge clk);
      if (rdy) begin
        if (w && memWrite) dut_mem[s_addr[7:0]] = s_wd;
        if (w) ref_mem[ea[7:0]] = eb;
        i++;
      end
      iters++;
      if (iters > 40) begin
        check_value("access_timeout", 32'(iters), 32'(n + exp_stalls));
        i = n;
      end
    end
    check_value("latency", 32'(iters), 32'(n + exp_stalls));
    @(negedge clk);
    memReady = 1;
    check_value("resp_valid", {31'h0, respValid}, 32'h1);
    check_value("resp_err", {31'h0, respErr}, 32'h0);
    check_value("resp_strobes", {30'h0, memRead, memWrite}, 32'h0);
    check_value("resp_ready_low", {31'h0, reqReady}, 32'h0);
    check_value("read_data", readData, exp_rd);
    @(negedge clk);
    check_value("resp_drop", {31'h0, respValid}, 32'h0);
    check_value("ready_back", {31'h0, reqReady}, 32'h1);
    check_value("read_data_hold", readData, exp_rd);
  endtask

  initial begin
    int          mism;
    logic [2:0]  rop;
    logic [31:0] raddr;
    logic [7:0]  v;
    for (int k = 0; k < 256; k++) begin
      v = 8'($urandom);
      dut_mem[k] = v;
      ref_mem[k] = v;
    end
    rst_n = 0; reqValid = 1; reqWrite = 1; address = 32'h100; writeData = 32'h12345678;
    MemOp = DM_WORD; memReady = 1;
    repeat (3) @(negedge clk);
    check_value("reset_ready", {31'h0, reqReady}, 32'h1);
    check_value("reset_outs", {28'h0, respValid, respErr, memRead, memWrite}, 32'h0);
    check_value("reset_mem_addr", memAddr, 32'h0);
    check_value("reset_read_data", readData, 32'h0);
    reqValid = 0;
    rst_n = 1;
    @(negedge clk);

    // Word store, then loads with each extension flavour
    do_req(1, 32'h100, 32'hDEADBEEF, DM_WORD, -1, 0, -1);
    check_value("store_b0", {24'h0, dut_mem[8'h00]}, 32'hEF);
    check_value("store_b3", {24'h0, dut_mem[8'h03]}, 32'hDE);
    do_req(0, 32'h100, 32'h0, DM_BYTE, -1, 0, -1);
    do_req(0, 32'h100, 32'h0, DM_BYTE_UNSIGNED, -1, 0, -1);
    do_req(0, 32'h102, 32'h0, DM_HALF, -1, 0, -1);
    do_req(0, 32'h100, 32'h0, DM_WORD, -1, 0, -1);
    check_value("word_load_const", readData, 32'hDEADBEEF);
    // Two-cycle stall on byte 1
    do_req(0, 32'h100, 32'h0, DM_WORD, 1, 2, -1);
    check_value("stall_load_const", readData, 32'hDEADBEEF);
    // Misaligned word, then an undefined MemOp
    do_req(0, 32'h101, 32'h0, DM_WORD, -1, 0, -1);
    do_req(0, 32'h100, 32'h0, 3'b111, -1, 0, -1);
    do_req(1, 32'h100, 32'h0, DM_HALF_UNSIGNED, -1, 0, -1);
    // Reset after two bytes of a store
    do_req(1, 32'h140, 32'hA1B2C3D4, DM_WORD, -1, 0, 2);
    do_req(0, 32'h140, 32'h0, DM_WORD, -1, 0, -1);
    // Address wrap
    do_req(0, 32'hFFFFFFFE, 32'h0, DM_WORD, -1, 0, -1);

    for (int r = 0; r < 60; r++) begin
      rop   = 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'h100 + $urandom_range(0, 31);
      do_req(1'($urandom), raddr, $urandom, rop,
             $urandom_range(0, 4), $urandom_range(0, 3), -1);
    end

    mism = 0;
    for (int k = 0; k < 256; k++) if (dut_mem[k] !== ref_mem[k]) mism++;
    check_value("mem_image", 32'(mism), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_byte_master.md
# lsu_byte_master

Load/store initiator that sits between the CPU's memory stage and a byte-wide data memory port. It accepts one load or store request at a time and serialises it into 1, 2 or 4 single-byte accesses in little-endian order. For loads it assembles and sign- or zero-extends the returned bytes, then reports completion with a one-cycle response pulse. The CPU stalls on `reqReady` while the block is busy.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: request and memory address width.
- `DATA_WIDTH`, 32: request data width; fixed at 32 for RV32.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqValid` in 1: a request is present.
- `reqReady` out 1: the block can accept a request; high only in IDLE.
- `reqWrite` in 1: 1 = store, 0 = load.
- `address` in ADDR_WIDTH: byte address.
- `writeData` in DATA_WIDTH: store data, LSB-aligned.
- `MemOp` in 3: access type; uses the shared `DM_*` encodings.
- `respValid` out 1: one-cycle completion pulse.
- `respErr` out 1: valid with `respValid`; 1 = request rejected, no memory access made.
- `readData` out DATA_WIDTH: extended load result.
- `memAddr` out ADDR_WIDTH: current byte address.
- `memWData` out 8: store byte.
- `memRData` in 8: load byte; combinational from `memAddr`.
- `memRead` out 1: byte read strobe.
- `memWrite` out 1: byte write strobe.
- `memReady` in 1: memory completes the current byte this cycle.

## Operation
- The state machine has three states: IDLE, ACCESS and RESP.
- **Accept:** the block accepts a request on `reqValid && reqReady`. It latches `address` as base, plus `writeData`, `MemOp` and `reqWrite`. It clears the byte index and the read-assembly register.
- **Byte count n** is set by `MemOp`:
  - `DM_BYTE` and `DM_BYTE_UNSIGNED`: n = 1.
  - `DM_HALF` and `DM_HALF_UNSIGNED`: n = 2.
  - `DM_WORD`: n = 4.
- **Invalid requests:**
  - Any other `MemOp` encoding is invalid.
  - A store with `DM_BYTE_UNSIGNED` or `DM_HALF_UNSIGNED` is invalid.
  - An invalid request goes IDLE→RESP with `respErr=1`.
- **ACCESS:**
  - Outputs: `memAddr = base + idx`, truncated modulo 2^ADDR_WIDTH so the address wraps. `memRead = !write`, `memWrite = write`, and `memWData = wdata[8*idx+7:8*idx]`.
  - On `memReady`: a load captures `memRData` into bits [8*idx+7:8*idx], and idx increments.
  - After byte n-1 completes the block goes to RESP.
  - Without `memReady`, all outputs hold.
- **RESP:**
  - `respValid=1` for exactly one cycle, then the block returns to IDLE.
  - `respValid` has no back-pressure.
  - `readData` holds the sign-extended (signed ops) or zero-extended (unsigned, word) value, for loads only. It is stable from RESP until the next accept. For stores and errors it is 0.
- **Reset:** asynchronous reset forces IDLE at any point, including mid-access.
  - Bytes already written stay in memory.
  - No `respValid` is issued for the aborted request.

## Timing
- **Reset values:** state IDLE, `reqReady=1`, and every other output 0. Requests are ignored while `rst_n=0`.
- **Normal access:** for an accept at edge k with `memReady` held at 1:
  - Byte i is presented in the cycle after edge k+i.
  - `respValid` is high in the cycle after edge k+n.
  - `reqReady` returns high after edge k+n+1.
  - Throughput is one request per n+2 cycles.
- **Error access:** for an error accepted at edge k, `respValid` is high in the cycle after edge k, and `reqReady` is high again after edge k+1.
- **Stalls:** each cycle of `memReady=0` in ACCESS adds exactly one cycle of latency.
- **Unused strobes:** `memRead` and `memWrite` are never asserted outside ACCESS.

## Configuration
- **Macro:** `LSU_ALIGN_CHECK_EN`.
- **Defined:** a misaligned access is rejected with `respErr=1` and no memory access. Misaligned means a half with `address[0]=1`, or a word with `address[1:0]≠0`.
- **Undefined:** misaligned accesses proceed byte-serially from the unaligned base. Only an invalid `MemOp` raises `respErr`.

## Structure
- **Shared definitions:** the `DM_*` MemOp encodings and the `BYTE`/`HALF`/`WORD` width constants come from the shared `Defines.v` package. The FSM state encodings are also added there.
- **Sub-module `lsu_extend`:** a combinational block taking the 32-bit assembly register and `MemOp`, and producing the extended `readData`.

## Test plan
1. **Word store:** `DM_WORD` store of 0xDEADBEEF at 0x100 with `memReady=1` → bytes EF, BE, AD, DE written at 0x100–0x103 on consecutive cycles. `respValid` follows 4 cycles after the accept cycle, with `respErr=0`.
2. **Loads and extension** (memory preloaded as in scenario 1):
   - `DM_BYTE` at 0x100 → 0xFFFFFFEF.
   - `DM_BYTE_UNSIGNED` at 0x100 → 0x000000EF.
   - `DM_HALF` at 0x102 → 0xFFFFDEAD.
   - `DM_WORD` at 0x100 → 0xDEADBEEF.
3. **Stall:** word load with `memReady` low for 2 cycles while on byte 1 → `memAddr` holds 0x101 and the strobes hold. `respValid` is delayed by exactly 2 cycles and the data is unchanged.
4. **Misaligned word** load at 0x101:
   - With `LSU_ALIGN_CHECK_EN`: `respErr=1`, no strobes, `respValid` one cycle after accept.
   - Without it: reads at 0x101–0x104 and `respErr=0`.
   - Either way, a `MemOp` of 3'b111 → `respErr=1`.
5. **Reset mid-store:** assert `rst_n=0` after 2 bytes of a word store → all outputs take their reset values immediately, and only 2 bytes are modified. There is no `respValid`, and the next request completes normally.
6. **Address wrap:** `DM_WORD` load at 0xFFFFFFFE → `memAddr` sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
